// File: rtl/ccff_chain_loader.sv
// Purpose: streams word-wide bitstream data onto a CCFF configuration chain and returns ccff_tail bits as readback words.
// Latency: a word accepted in cycle N shifts its bit 0 in cycle N+1; done pulses one cycle after the final readback handshake.
// Backpressure: cfg_ready follows a one-word input buffer; a pending readback word with rb_ready low freezes shifting and cfg_ready.
//
// Ports:
//   prog_clk, prog_reset         configuration clock, synchronous active-high reset
//   start / busy / done / err    load request, LOAD|DRAIN indicator, completion pulse, sticky cfg_last error
//   cfg_data/last/valid/ready    bitstream word stream (bit 0 shifted first, cfg_last on word NWORDS-1)
//   ccff_head/shift_en/tail      serial chain interface
//   rb_data/valid/ready          readback word stream (first tail bit in bit 0)
module ccff_chain_loader #(
   parameter int CHAIN_LEN = 64,
   parameter int WORD_W    = 8
) (
   input  logic              prog_clk,
   input  logic              prog_reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              err,
   input  logic [WORD_W-1:0] cfg_data,
   input  logic              cfg_last,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   input  logic              ccff_tail,
   output logic [WORD_W-1:0] rb_data,
   output logic              rb_valid,
   input  logic              rb_ready
);

   localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
   // Valid bits carried by the final (possibly short) word.
   localparam int LAST_BITS = CHAIN_LEN - (NWORDS - 1) * WORD_W;
   localparam int CW        = $clog2(CHAIN_LEN + 1);
   localparam int WCW       = $clog2(NWORDS + 1);
   localparam int BCW       = $clog2(WORD_W + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t            state;

   // Input buffer: one word plus the number of its bits still to shift.
   logic [WORD_W-1:0] buf_dat;
   logic [BCW-1:0]    buf_cnt;
   logic [WCW-1:0]    words_acc;

   // Chain position and readback assembly.
   logic [CW-1:0]     bit_cnt;
   logic [WORD_W-1:0] rb_sr;
   logic [BCW-1:0]    rb_cnt;

   logic              stall;
   logic              in_load;
   logic              shift;
   logic              accept;
   logic              acc_is_last;
   logic              last_chain_bit;
   logic              rb_full;
   logic [WORD_W-1:0] next_sr;

   always_comb begin
      // A readback word waiting on the sink blocks the chain so no tail bit is lost.
      stall          = rb_valid & ~rb_ready;
      in_load        = (state == S_LOAD);
      shift          = in_load & (buf_cnt != '0) & ~stall;
      // Refill either into an empty buffer or in the same cycle its last bit leaves,
      // which keeps back-to-back words bubble-free.
      cfg_ready      = in_load & ~stall & (words_acc < WCW'(NWORDS)) &
                       ((buf_cnt == '0) | ((buf_cnt == BCW'(1)) & shift));
      accept         = cfg_ready & cfg_valid;
      acc_is_last    = (words_acc == WCW'(NWORDS - 1));
      last_chain_bit = (bit_cnt == CW'(CHAIN_LEN - 1));
      rb_full        = (rb_cnt == BCW'(WORD_W - 1)) | last_chain_bit;
      ccff_shift_en  = shift;
      ccff_head      = shift & buf_dat[0];

      // Tail bit lands at the next free position; unused upper bits stay 0.
      next_sr = rb_sr;
      for (int i = 0; i < WORD_W; i++) begin
         if (rb_cnt == BCW'(i)) begin
            next_sr[i] = ccff_tail;
         end
      end
   end

   always_ff @(posedge prog_clk) begin
      if (prog_reset) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         buf_dat   <= '0;
         buf_cnt   <= '0;
         words_acc <= '0;
         bit_cnt   <= '0;
         rb_sr     <= '0;
         rb_cnt    <= '0;
         rb_data   <= '0;
         rb_valid  <= 1'b0;
      end else begin
         done <= 1'b0;

         if (rb_valid && rb_ready) begin
            rb_valid <= 1'b0;
         end

         case (state)
            S_IDLE: begin
               if (start) begin
                  state     <= S_LOAD;
                  busy      <= 1'b1;
                  err       <= 1'b0;
                  bit_cnt   <= '0;
                  words_acc <= '0;
                  buf_cnt   <= '0;
                  rb_cnt    <= '0;
                  rb_sr     <= '0;
               end
            end

            S_LOAD: begin
               if (accept) begin
                  buf_dat   <= cfg_data;
                  // Upper bits of the short final word are never counted, so never shifted.
                  buf_cnt   <= acc_is_last ? BCW'(LAST_BITS) : BCW'(WORD_W);
                  words_acc <= words_acc + WCW'(1);
                  if (cfg_last != acc_is_last) begin
                     err <= 1'b1;
                  end
               end else if (shift) begin
                  buf_dat <= buf_dat >> 1;
                  buf_cnt <= buf_cnt - BCW'(1);
               end

               if (shift) begin
                  bit_cnt <= bit_cnt + CW'(1);
                  if (rb_full) begin
                     // Only reachable when rb_valid is low or handshaking now,
                     // so rb_data never changes under a pending word.
                     rb_data  <= next_sr;
                     rb_valid <= 1'b1;
                     rb_sr    <= '0;
                     rb_cnt   <= '0;
                  end else begin
                     rb_sr  <= next_sr;
                     rb_cnt <= rb_cnt + BCW'(1);
                  end
                  if (last_chain_bit) begin
                     state <= S_DRAIN;
                  end
               end
            end

            S_DRAIN: begin
               // Leave as soon as the final readback word is gone or leaving this cycle.
               if (!rb_valid || rb_ready) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end

            S_DONE: begin
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ccff_chain_loader.sv
module tb_ccff_chain_loader;

   localparam int CL = 20;
   localparam int WW = 8;

   logic          prog_clk = 1'b0;
   logic          prog_reset;
   logic          start;
   logic          busy;
   logic          done;
   logic          err;
   logic [WW-1:0] cfg_data;
   logic          cfg_last;
   logic          cfg_valid;
   logic          cfg_ready;
   logic          ccff_head;
   logic          ccff_shift_en;
   logic          ccff_tail;
   logic [WW-1:0] rb_data;
   logic          rb_valid;
   logic          rb_ready;

   int checks = 0;
   int passes = 0;

   always #5 prog_clk = ~prog_clk;

   ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
      .prog_clk      (prog_clk),
      .prog_reset    (prog_reset),
      .start         (start),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .cfg_data      (cfg_data),
      .cfg_last      (cfg_last),
      .cfg_valid     (cfg_valid),
      .cfg_ready     (cfg_ready),
      .ccff_head     (ccff_head),
      .ccff_shift_en (ccff_shift_en),
      .ccff_tail     (ccff_tail),
      .rb_data       (rb_data),
      .rb_valid      (rb_valid),
      .rb_ready      (rb_ready)
   );

   // Chain model: bit 0 is the tail end, head enters at the top.
   logic [CL-1:0] chain = '0;
   logic [CL-1:0] chain_init = '0;
   logic          chain_load = 1'b0;
   always @(posedge prog_clk) begin
      if (chain_load) chain <= chain_init;
      else if (ccff_shift_en) chain <= {ccff_head, chain[CL-1:1]};
   end
   assign ccff_tail = chain[0];

   // Event recorder, sampled mid-cycle.
   int            cyc = 0;
   int            done_cnt = 0;
   int            done_cyc = 0;
   int            rb_hs_cyc = 0;
   int            stall_cyc = 0;
   int            stall_viol = 0;
   int            idle_rdy = 0;
   logic          head_q[$];
   int            shift_cyc_q[$];
   int            acc_cyc_q[$];
   logic [WW-1:0] rb_q[$];
   logic          prev_pend = 1'b0;
   logic [WW-1:0] prev_dat = '0;

   always @(negedge prog_clk) begin
      cyc++;
      if (ccff_shift_en) begin
         head_q.push_back(ccff_head);
         shift_cyc_q.push_back(cyc);
      end
      if (cfg_valid && cfg_ready) acc_cyc_q.push_back(cyc);
      if (rb_valid && rb_ready) begin
         rb_q.push_back(rb_data);
         rb_hs_cyc = cyc;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (cfg_ready && !busy) idle_rdy++;
      if (rb_valid && !rb_ready) begin
         stall_cyc++;
         if (ccff_shift_en || cfg_ready) stall_viol++;
         if (prev_pend && rb_data !== prev_dat) stall_viol++;
         prev_pend = 1'b1;
         prev_dat  = rb_data;
      end else begin
         prev_pend = 1'b0;
      end
   end

   task automatic pulse_start();
      start = 1'b1;
      @(posedge prog_clk); #1;
      start = 1'b0;
   endtask

   task automatic preload_chain(input logic [CL-1:0] v);
      chain_init = v;
      chain_load = 1'b1;
      @(posedge prog_clk); #1;
      chain_load = 1'b0;
   endtask

   task automatic send_word(input logic [WW-1:0] d, input logic l, output bit ok);
      bit got;
      got = 1'b0;
      cfg_data  = d;
      cfg_last  = l;
      cfg_valid = 1'b1;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge prog_clk);
         if (cfg_ready) got = 1'b1;
         @(posedge prog_clk); #1;
      end
      ok = got;
   endtask

   // One full load of three words; optional readback stall of stall_len cycles
   // starting when the first readback word appears.
   task automatic run_load(input logic [23:0] words, input logic [2:0] lasts,
                           input int stall_len, output bit ok);
      int d0;
      bit s_ok;
      bit r_ok;
      bit d_ok;
      d0   = done_cnt;
      s_ok = 1'b1;
      r_ok = 1'b1;
      d_ok = 1'b0;
      if (stall_len > 0) rb_ready = 1'b0;
      pulse_start();
      fork
         begin
            for (int k = 0; k < 3; k++) begin
               bit w_ok;
               send_word(words[8*k +: 8], lasts[k], w_ok);
               if (!w_ok) s_ok = 1'b0;
            end
            cfg_valid = 1'b0;
            cfg_last  = 1'b0;
         end
         begin
            if (stall_len > 0) begin
               bit seen;
               seen = 1'b0;
               for (int i = 0; i < 200 && !seen; i++) begin
                  if (rb_valid) seen = 1'b1;
                  else begin @(posedge prog_clk); #1; end
               end
               if (!seen) r_ok = 1'b0;
               repeat (stall_len) begin @(posedge prog_clk); #1; end
               rb_ready = 1'b1;
            end
         end
      join
      for (int i = 0; i < 200 && !d_ok; i++) begin
         if (done_cnt != d0) d_ok = 1'b1;
         else begin @(posedge prog_clk); #1; end
      end
      ok = s_ok && r_ok && d_ok;
   endtask

   function automatic logic [23:0] rb_words(input int base);
      logic [23:0] v;
      v = 'x;
      if (rb_q.size() >= base + 3) v = {rb_q[base+2], rb_q[base+1], rb_q[base]};
      return v;
   endfunction

   task automatic test_reset();
      prog_reset = 1'b1;
      start = 1'b0; cfg_valid = 1'b0; cfg_data = '0; cfg_last = 1'b0; rb_ready = 1'b1;
      repeat (3) @(posedge prog_clk);
      #1;
      checks++;
      if ({busy, done, err} !== 3'b000) $display("FAIL reset_status got=%b exp=000", {busy, done, err});
      else passes++;
      checks++;
      if (cfg_ready !== 1'b0) $display("FAIL reset_cfg_ready got=%b exp=0", cfg_ready);
      else passes++;
      checks++;
      if ({ccff_head, ccff_shift_en} !== 2'b00) $display("FAIL reset_chain got=%b exp=00", {ccff_head, ccff_shift_en});
      else passes++;
      checks++;
      if ({rb_valid, rb_data} !== 9'h000) $display("FAIL reset_rb got=%h exp=000", {rb_valid, rb_data});
      else passes++;
      prog_reset = 1'b0;
      @(posedge prog_clk); #1;
   endtask

   task automatic test_basic();
      int h0, a0, r0, d0;
      bit ok;
      logic [CL-1:0] hseq;
      preload_chain(20'h51234);
      h0 = head_q.size(); a0 = acc_cyc_q.size(); r0 = rb_q.size(); d0 = done_cnt;
      run_load({8'hFF, 8'h3C, 8'hA5}, 3'b100, 0, ok);
      checks++;
      if (!ok) $display("FAIL basic_timeout got=timeout exp=done");
      else passes++;
      checks++;
      if (head_q.size() - h0 !== 20) $display("FAIL basic_shifts got=%0d exp=20", head_q.size() - h0);
      else passes++;
      hseq = 'x;
      if (head_q.size() >= h0 + CL) for (int i = 0; i < CL; i++) hseq[i] = head_q[h0+i];
      checks++;
      if (hseq !== 20'hF3CA5) $display("FAIL basic_head_seq got=%h exp=f3ca5", hseq);
      else passes++;
      checks++;
      if (shift_cyc_q.size() < h0 + CL || shift_cyc_q[h0+CL-1] - shift_cyc_q[h0] !== CL - 1)
         $display("FAIL basic_contiguous got=not_contiguous exp=19_cycle_span");
      else passes++;
      checks++;
      if (shift_cyc_q.size() <= h0 || acc_cyc_q.size() <= a0 || shift_cyc_q[h0] - acc_cyc_q[a0] !== 1)
         $display("FAIL basic_first_latency got=wrong exp=1");
      else passes++;
      checks++;
      if (rb_q.size() - r0 !== 3) $display("FAIL basic_rb_count got=%0d exp=3", rb_q.size() - r0);
      else passes++;
      checks++;
      if (rb_words(r0) !== 24'h051234) $display("FAIL basic_rb_data got=%h exp=051234", rb_words(r0));
      else passes++;
      checks++;
      if (done_cnt - d0 !== 1) $display("FAIL basic_done_count got=%0d exp=1", done_cnt - d0);
      else passes++;
      checks++;
      if (done_cyc !== rb_hs_cyc + 1) $display("FAIL basic_done_timing got=%0d exp=%0d", done_cyc, rb_hs_cyc + 1);
      else passes++;
      checks++;
      if (err !== 1'b0) $display("FAIL basic_err got=%b exp=0", err);
      else passes++;
   endtask

   task automatic test_readback();
      int h0, r0;
      bit ok;
      h0 = head_q.size(); r0 = rb_q.size();
      run_load({8'h33, 8'h22, 8'h11}, 3'b100, 0, ok);
      checks++;
      if (!ok) $display("FAIL readback_timeout got=timeout exp=done");
      else passes++;
      checks++;
      if (head_q.size() - h0 !== 20) $display("FAIL readback_shifts got=%0d exp=20", head_q.size() - h0);
      else passes++;
      checks++;
      if (rb_words(r0) !== 24'h0F3CA5) $display("FAIL readback_data got=%h exp=0f3ca5", rb_words(r0));
      else passes++;
   endtask

   task automatic test_stall();
      int h0, r0, s0, v0;
      bit ok;
      h0 = head_q.size(); r0 = rb_q.size(); s0 = stall_cyc; v0 = stall_viol;
      run_load({8'h0A, 8'hF0, 8'h0F}, 3'b100, 10, ok);
      checks++;
      if (!ok) $display("FAIL stall_timeout got=timeout exp=done");
      else passes++;
      checks++;
      if (stall_cyc - s0 !== 10) $display("FAIL stall_cycles got=%0d exp=10", stall_cyc - s0);
      else passes++;
      checks++;
      if (stall_viol - v0 !== 0) $display("FAIL stall_frozen got=%0d exp=0", stall_viol - v0);
      else passes++;
      checks++;
      if (head_q.size() - h0 !== 20) $display("FAIL stall_shifts got=%0d exp=20", head_q.size() - h0);
      else passes++;
      checks++;
      if (rb_words(r0) !== 24'h032211) $display("FAIL stall_rb_data got=%h exp=032211", rb_words(r0));
      else passes++;
   endtask

   task automatic test_err();
      int h0, d0;
      bit ok;
      h0 = head_q.size(); d0 = done_cnt;
      run_load({8'h0F, 8'hC3, 8'h5A}, 3'b010, 0, ok);
      checks++;
      if (!ok) $display("FAIL err_timeout got=timeout exp=done");
      else passes++;
      checks++;
      if (err !== 1'b1) $display("FAIL err_sticky got=%b exp=1", err);
      else passes++;
      checks++;
      if (head_q.size() - h0 !== 20) $display("FAIL err_shifts got=%0d exp=20", head_q.size() - h0);
      else passes++;
      checks++;
      if (done_cnt - d0 !== 1) $display("FAIL err_done got=%0d exp=1", done_cnt - d0);
      else passes++;
      run_load({8'h03, 8'h02, 8'h01}, 3'b100, 0, ok);
      checks++;
      if (!ok || err !== 1'b0) $display("FAIL err_cleared got=%b exp=0", err);
      else passes++;
   endtask

   task automatic test_reset_midload();
      int n, h0, r0, d0;
      bit ok;
      n = 0;
      pulse_start();
      cfg_data = 8'hA5; cfg_last = 1'b0; cfg_valid = 1'b1;
      for (int i = 0; i < 50 && n < 7; i++) begin
         @(negedge prog_clk);
         if (ccff_shift_en) n++;
         if (n < 7) begin @(posedge prog_clk); #1; end
      end
      @(posedge prog_clk); #1;
      cfg_valid = 1'b0;
      prog_reset = 1'b1;
      d0 = done_cnt;
      @(posedge prog_clk); #1;
      checks++;
      if ({busy, done, err, cfg_ready, ccff_head, ccff_shift_en, rb_valid} !== 7'b0)
         $display("FAIL midreset_outputs got=%b exp=0000000 shifts_seen=%0d",
                  {busy, done, err, cfg_ready, ccff_head, ccff_shift_en, rb_valid}, n);
      else passes++;
      checks++;
      if (rb_data !== 8'h00) $display("FAIL midreset_rb_data got=%h exp=00", rb_data);
      else passes++;
      prog_reset = 1'b0;
      repeat (4) begin @(posedge prog_clk); #1; end
      checks++;
      if (done_cnt !== d0) $display("FAIL midreset_no_done got=%0d exp=%0d", done_cnt, d0);
      else passes++;
      h0 = head_q.size(); r0 = rb_q.size();
      run_load({8'h99, 8'h88, 8'h77}, 3'b100, 0, ok);
      checks++;
      if (!ok || head_q.size() - h0 !== 20) $display("FAIL midreset_fresh_shifts got=%0d exp=20", head_q.size() - h0);
      else passes++;
      checks++;
      if (rb_q.size() - r0 !== 3) $display("FAIL midreset_fresh_rb got=%0d exp=3", rb_q.size() - r0);
      else passes++;
   endtask

   task automatic test_ignore();
      int a0, h0, d0;
      bit ok;
      a0 = acc_cyc_q.size();
      cfg_data = 8'h5A; cfg_last = 1'b1; cfg_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge prog_clk);
         checks++;
         if (cfg_ready !== 1'b0) $display("FAIL idle_cfg_ready cycle=%0d got=%b exp=0", i, cfg_ready);
         else passes++;
         @(posedge prog_clk); #1;
      end
      cfg_valid = 1'b0; cfg_last = 1'b0;
      checks++;
      if (acc_cyc_q.size() !== a0) $display("FAIL idle_accept got=%0d exp=0", acc_cyc_q.size() - a0);
      else passes++;
      h0 = head_q.size(); d0 = done_cnt;
      fork
         run_load({8'h30, 8'h20, 8'h10}, 3'b100, 0, ok);
         begin
            repeat (6) @(posedge prog_clk);
            #1; start = 1'b1;
            @(posedge prog_clk); #1; start = 1'b0;
         end
      join
      checks++;
      if (!ok || head_q.size() - h0 !== 20) $display("FAIL busy_start_shifts got=%0d exp=20", head_q.size() - h0);
      else passes++;
      checks++;
      if (done_cnt - d0 !== 1) $display("FAIL busy_start_done got=%0d exp=1", done_cnt - d0);
      else passes++;
      repeat (3) begin @(posedge prog_clk); #1; end
      checks++;
      if (busy !== 1'b0) $display("FAIL busy_start_relaunch got=%b exp=0", busy);
      else passes++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_readback();
      test_stall();
      test_err();
      test_reset_midload();
      test_ignore();
      checks++;
      if (idle_rdy !== 0) $display("FAIL ready_outside_load got=%0d exp=0", idle_rdy);
      else passes++;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
